// File: rtl/mux8_scan_controller.sv
// -----------------------------------------------------------------------------
// mux8_scan_controller
//
// Walks the select lines of a downstream 8:1 multiplexer through channels 0..7.
// Each enabled channel is given SETTLE cycles of settling time before the mux
// output y is sampled. Each sample lands in one bit of an 8-bit result word.
// Masked channels take one cycle and read as 0. The controller uses a one-shot
// start / busy / done handshake.
//
// Optional feature macro: MUX8_SCAN_PARITY_EN
//   When defined, adds the registered 'parity' output. It is the XOR of the
//   eight result bits and updates together with data_out.
//
// Parameters
//   SETTLE    settle cycles per enabled channel, legal range 1..15
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     scan request, only honoured in IDLE
//   mask[7:0] channel enables, captured when a scan is accepted
//   y         mux output, combinational from s2/s1/s0
//   s0,s1,s2  registered select lines, {s2,s1,s0} = current channel
//   busy      high in every state except IDLE
//   done      one-cycle pulse while data_out holds a fresh result
//   data_out  result word, bit i = sampled y of channel i (0 if masked)
//   parity    even-parity bit of data_out (MUX8_SCAN_PARITY_EN only)
// -----------------------------------------------------------------------------
module mux8_scan_controller #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mask,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
`ifdef MUX8_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // The counter runs 0..SETTLE-1, so the last settle cycle is the one where
  // the counter equals SETTLE-1.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [2:0] ch;
  logic [3:0] cnt;
  logic [7:0] mask_q;
  logic [7:0] work;
  logic [7:0] work_next;
  logic       adv;
  logic       last_ch;
  logic       settle_last;

  // Advance happens on a masked CHECK or at the end of SAMPLE. The word that
  // includes the current channel's bit is formed here. On channel 7 it goes
  // straight into data_out, so the result is already valid during DONE.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    adv         = ((state == S_CHECK) && !mask_q[ch]) || (state == S_SAMPLE);
    last_ch     = (ch == 3'd7);
    settle_last = (cnt == SETTLE_LAST);
    work_next     = work;
    work_next[ch] = (state == S_SAMPLE) ? y : 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CHECK;
      S_CHECK: begin
        if (mask_q[ch])   next_state = S_SETTLE;
        else if (last_ch) next_state = S_DONE;
        else              next_state = S_CHECK;
      end
      S_SETTLE: if (settle_last) next_state = S_SAMPLE;
      S_SAMPLE: next_state = last_ch ? S_DONE : S_CHECK;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state. The selects come straight from
  // the channel register, so they never glitch.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    {s2, s1, s0} = ch;
  end

  // Datapath: channel, settle counter, captured mask, work and result words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch       <= 3'd0;
      cnt      <= 4'd0;
      mask_q   <= 8'h00;
      work     <= 8'h00;
      data_out <= 8'h00;
`ifdef MUX8_SCAN_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= mask;
            work   <= 8'h00;
            ch     <= 3'd0;
          end
        end
        S_CHECK:  if (mask_q[ch]) cnt <= 4'd0;
        S_SETTLE: cnt <= cnt + 4'd1;
        S_DONE:   ch  <= 3'd0;
        default:  ;
      endcase

      if (adv) begin
        work <= work_next;
        if (last_ch) begin
          // Channel stays at 7 through DONE. It returns to 0 on the DONE edge.
          data_out <= work_next;
`ifdef MUX8_SCAN_PARITY_EN
          parity   <= ^work_next;
`endif
        end else begin
          ch <= ch + 3'd1;
        end
      end
    end
  end

endmodule
